mux_nx1_scan: RTL and testbench

MUX_NX1_SCAN -- requirements
Module: mux_nx1_scan

---
 rtl/mux_pkg.sv | 19 +
 rtl/tick_gen.sv | 30 +++
 rtl/mux_nx1_scan.sv | 115 +++++++++++
 tb/tb_mux_nx1_scan.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared types and constants for the scanning N:1 mux: FSM state encoding
// and the i_mode encoding.
package mux_pkg;

    typedef enum logic [1:0] {
        ST_MANUAL = 2'd0,
        ST_SCAN   = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Width of a channel index; never narrower than one bit.
    function automatic int ch_width(input int n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Auto-scan divider: counts 0..SCAN_DIV-1 while enabled and flags the
// terminal count combinationally; holds its value while disabled.
module tick_gen #(
    parameter int SCAN_DIV = 50000000
) (
    input  logic iCLK,
    input  logic iRST,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    assign tick = enable && (r_cnt == LP_LAST);

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (enable) begin
            r_cnt <= tick ? '0 : r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mux_nx1_scan.sv
// Registered N:1 channel mux with manual select, timed auto-scan and a
// freeze input; hold takes priority over mode.
module mux_nx1_scan
    import mux_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int N_CH     = 4,
    parameter int SCAN_DIV = 50000000,
    localparam int CW      = ch_width(N_CH)
) (
    input  logic                  iCLK,
    input  logic                  iRST,
    input  logic [N_CH*WIDTH-1:0] i_data,
    input  logic [CW-1:0]         i_sel,
    input  logic                  i_mode,
    input  logic                  i_hold,
    output logic [WIDTH-1:0]      out_mux,
    output logic [CW-1:0]         out_ch,
    output logic                  out_step,
    output logic                  out_err,
    output state_t                o_dbg_state
);

    localparam logic [CW:0]   LP_NCH     = (CW + 1)'(N_CH);
    localparam logic [CW-1:0] LP_LAST_CH = CW'(N_CH - 1);

    state_t            r_state;
    state_t            w_next_state;
    logic [WIDTH-1:0]  r_mux;
    logic [CW-1:0]     r_ch;
    logic              r_step;
    logic              r_err;
    logic [CW-1:0]     w_next_ch;
    logic              w_next_step;
    logic              w_next_err;
    logic [WIDTH-1:0]  w_mux_data;
    logic              w_scan_en;
    logic              w_clr;
    logic              w_tick;

    // Divider controls come straight from the inputs so the terminal-count
    // flag has no path back through the next-state logic.
    assign w_scan_en = ~i_hold & (i_mode == MODE_SCAN);
    assign w_clr     = ~i_hold & (i_mode == MODE_MANUAL);

    tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick_gen (
        .iCLK   (iCLK),
        .iRST   (iRST),
        .enable (w_scan_en),
        .clear  (w_clr),
        .tick   (w_tick)
    );

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_state <= ST_MANUAL;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = ST_MANUAL;
        w_next_ch    = r_ch;
        w_next_step  = 1'b0;
        w_next_err   = 1'b0;
        if (i_hold) begin
            w_next_state = ST_HOLD;
        end else if (i_mode == MODE_SCAN) begin
            w_next_state = ST_SCAN;
            if (w_tick) begin
                w_next_ch   = (r_ch == LP_LAST_CH) ? '0 : r_ch + CW'(1);
                w_next_step = 1'b1;
            end
        end else begin
            if ({1'b0, i_sel} < LP_NCH) begin
                w_next_ch = i_sel;
            end else begin
                w_next_err = 1'b1;
            end
        end
    end

    always_comb begin
        w_mux_data = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (w_next_ch == CW'(k)) begin
                w_mux_data = i_data[k*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_mux  <= '0;
            r_ch   <= '0;
            r_step <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_step <= w_next_step;
            r_err  <= w_next_err;
            if (w_next_state != ST_HOLD) begin
                r_ch  <= w_next_ch;
                r_mux <= w_mux_data;
            end
        end
    end

    assign out_mux     = r_mux;
    assign out_ch      = r_ch;
    assign out_step    = r_step;
    assign out_err     = r_err;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mux_nx1_scan.sv
// Directed bench for mux_nx1_scan: a 4-channel build and a 3-channel build
// sharing one clock and reset, SCAN_DIV=3.
module tb_mux_nx1_scan;
    import mux_pkg::*;

    logic        iCLK;
    logic        iRST;

    logic [15:0] data4;
    logic [1:0]  sel4;
    logic        mode4, hold4;
    logic [3:0]  mux4;
    logic [1:0]  ch4;
    logic        step4, err4;
    state_t      st4;

    logic [11:0] data3;
    logic [1:0]  sel3;
    logic        mode3, hold3;
    logic [3:0]  mux3;
    logic [1:0]  ch3;
    logic        step3, err3;
    state_t      st3;

    int n_checks = 0;
    int n_fail   = 0;

    int exp_ch4  [9] = '{2, 2, 3, 3, 3, 0, 0, 0, 1};
    int exp_mux4 [9] = '{'hC, 'hC, 'hD, 'hD, 'hD, 'hA, 'hA, 'hA, 'hB};
    int exp_stp4 [9] = '{0, 0, 1, 0, 0, 1, 0, 0, 1};
    int exp_ch3  [6] = '{1, 1, 2, 2, 2, 0};
    int exp_mux3 [6] = '{'hB, 'hB, 'hC, 'hC, 'hC, 'hA};
    int exp_stp3 [6] = '{0, 0, 1, 0, 0, 1};

    mux_nx1_scan #(.WIDTH(4), .N_CH(4), .SCAN_DIV(3)) dut4 (
        .iCLK(iCLK), .iRST(iRST), .i_data(data4), .i_sel(sel4),
        .i_mode(mode4), .i_hold(hold4), .out_mux(mux4), .out_ch(ch4),
        .out_step(step4), .out_err(err4), .o_dbg_state(st4)
    );

    mux_nx1_scan #(.WIDTH(4), .N_CH(3), .SCAN_DIV(3)) dut3 (
        .iCLK(iCLK), .iRST(iRST), .i_data(data3), .i_sel(sel3),
        .i_mode(mode3), .i_hold(hold3), .out_mux(mux3), .out_ch(ch3),
        .out_step(step3), .out_err(err3), .o_dbg_state(st3)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    task automatic tick_n(input int n);
        repeat (n) @(posedge iCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk4(input string tag, input int ch, input int mx, input int stp, input int er);
        chk({tag, "_ch"},   32'(ch4),   32'(ch));
        chk({tag, "_mux"},  32'(mux4),  32'(mx));
        chk({tag, "_step"}, 32'(step4), 32'(stp));
        chk({tag, "_err"},  32'(err4),  32'(er));
    endtask

    task automatic chk3(input string tag, input int ch, input int mx, input int stp, input int er);
        chk({tag, "_ch"},   32'(ch3),   32'(ch));
        chk({tag, "_mux"},  32'(mux3),  32'(mx));
        chk({tag, "_step"}, 32'(step3), 32'(stp));
        chk({tag, "_err"},  32'(err3),  32'(er));
    endtask

    initial begin
        iRST  = 1'b1;
        data4 = 16'hDCBA; sel4 = 2'd0; mode4 = MODE_MANUAL; hold4 = 1'b0;
        data3 = 12'hCBA;  sel3 = 2'd0; mode3 = MODE_MANUAL; hold3 = 1'b0;

        // reset state
        tick_n(3);
        chk4("rst4", 0, 0, 0, 0);
        chk("rst4_state", 32'(st4), 32'(ST_MANUAL));
        chk3("rst3", 0, 0, 0, 0);
        iRST = 1'b0;

        // manual select and data latency
        sel4 = 2'd2;
        tick_n(1);
        chk4("man_sel2", 2, 'hC, 0, 0);
        data4 = 16'hD5BA;
        tick_n(1);
        chk4("man_data5", 2, 'h5, 0, 0);
        data4 = 16'hDCBA;
        tick_n(1);
        chk4("man_dataC", 2, 'hC, 0, 0);

        // auto-scan from channel 2 with wrap
        mode4 = MODE_SCAN;
        for (int i = 0; i < 9; i++) begin
            tick_n(1);
            chk4($sformatf("scan_c%0d", i + 1), exp_ch4[i], exp_mux4[i], exp_stp4[i], 0);
        end
        chk("scan_state", 32'(st4), 32'(ST_SCAN));

        // hold asserted on the terminal-count cycle
        tick_n(2);
        chk4("pre_hold", 1, 'hB, 0, 0);
        hold4 = 1'b1;
        data4 = 16'h1234;
        for (int i = 0; i < 5; i++) begin
            tick_n(1);
            chk4($sformatf("hold_c%0d", i + 1), 1, 'hB, 0, 0);
        end
        chk("hold_state", 32'(st4), 32'(ST_HOLD));
        data4 = 16'hDCBA;
        hold4 = 1'b0;
        tick_n(1);
        chk4("hold_release", 2, 'hC, 1, 0);
        tick_n(1);
        chk4("hold_after", 2, 'hC, 0, 0);

        // reset mid-scan at divider=2, channel 3
        tick_n(4);
        chk4("pre_rst", 3, 'hD, 0, 0);
        iRST = 1'b1;
        #2;
        chk4("async_rst", 0, 0, 0, 0);
        chk("async_rst_state", 32'(st4), 32'(ST_MANUAL));
        #2;
        iRST = 1'b0;
        tick_n(1);
        chk4("post_rst_c1", 0, 'hA, 0, 0);
        tick_n(1);
        chk4("post_rst_c2", 0, 'hA, 0, 0);
        tick_n(1);
        chk4("post_rst_c3", 1, 'hB, 1, 0);

        // back to manual clears the step pulse
        mode4 = MODE_MANUAL;
        sel4  = 2'd3;
        tick_n(1);
        chk4("back_manual", 3, 'hD, 0, 0);
        chk("back_manual_state", 32'(st4), 32'(ST_MANUAL));

        // three-channel build: out-of-range select
        sel3 = 2'd2;
        tick_n(1);
        chk3("n3_sel2", 2, 'hC, 0, 0);
        sel3 = 2'd3;
        tick_n(1);
        chk3("n3_sel3", 2, 'hC, 0, 1);
        sel3 = 2'd1;
        tick_n(1);
        chk3("n3_sel1", 1, 'hB, 0, 0);

        // three-channel scan wraps 2 -> 0; error forced low while scanning
        mode3 = MODE_SCAN;
        sel3  = 2'd3;
        for (int i = 0; i < 6; i++) begin
            tick_n(1);
            chk3($sformatf("n3_scan_c%0d", i + 1), exp_ch3[i], exp_mux3[i], exp_stp3[i], 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
